// File: rtl/ica_easi_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ica_easi_seq
//  Description : Two-channel EASI blind-source separator. One sample pair is
//                accepted per valid/ready handshake. The block then computes
//                y = B*x, the H matrix, dB = H*B and B += mu*dB. All of this
//                runs on one shared signed multiplier, one product per cycle,
//                sequenced by an FSM. The live B matrix is always visible on
//                the B*_out ports.
//  Option      : ICA_MIX_EN - when defined, in1/in2 are treated as sources
//                s1/s2. They first pass through a fixed 2x2 mixing matrix
//                (MIX state), and the latency grows from 22 to 26 cycles.
//  Ports       : clk, reset (async, active-low)
//                in_valid/in_ready, in1, in2, mu, adapt_en - sample input
//                clear_b   - reload B with identity (IDLE only)
//                out_valid/out_ready, y1_out, y2_out - separated components
//                x1_out, x2_out - inputs actually used by the separator
//                B11_out..B22_out - demixing matrix; busy - FSM not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module ica_easi_seq #(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] mu,
    input  logic         adapt_en,
    input  logic         clear_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y1_out,
    output logic [W-1:0] y2_out,
    output logic [W-1:0] x1_out,
    output logic [W-1:0] x2_out,
    output logic [W-1:0] B11_out,
    output logic [W-1:0] B12_out,
    output logic [W-1:0] B21_out,
    output logic [W-1:0] B22_out,
    output logic         busy
);

    localparam logic signed [W-1:0] c_one     = {{(W-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [W-1:0] c_neg_one = -c_one;
    localparam logic signed [W-1:0] c_max     = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] c_min     = {1'b1, {(W-1){1'b0}}};
`ifdef ICA_MIX_EN
    localparam logic signed [W-1:0] c_a11 = c_one - (c_one >>> 2);  // 0.75
    localparam logic signed [W-1:0] c_a12 = c_one + (c_one >>> 1);  // 1.5
    localparam logic signed [W-1:0] c_a21 = c_one >>> 1;            // 0.5
    localparam logic signed [W-1:0] c_a22 = c_one / 3;              // floor(ONE/3)
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
`ifdef ICA_MIX_EN
        S_MIX  = 3'd1,
`endif
        S_Y    = 3'd2,
        S_H    = 3'd3,
        S_DB   = 3'd4,
        S_UPD  = 3'd5,
        S_OUT  = 3'd6
    } state_t;

`ifdef ICA_MIX_EN
    localparam state_t c_first = S_MIX;
`else
    localparam state_t c_first = S_Y;
`endif

    // Saturate a (W+2)-bit intermediate into the W-bit signed range.
    function automatic logic signed [W-1:0] sat_w(input logic signed [W+1:0] v);
        logic signed [W+1:0] hi;
        logic signed [W+1:0] lo;
        hi = {3'b000, {(W-1){1'b1}}};
        lo = {3'b111, {(W-1){1'b0}}};
        if (v > hi)      sat_w = c_max;
        else if (v < lo) sat_w = c_min;
        else             sat_w = v[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] add_sat(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        add_sat = sat_w({{2{a[W-1]}}, a} + {{2{b[W-1]}}, b});
    endfunction

    function automatic logic signed [W-1:0] sub_sat(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        sub_sat = sat_w({{2{a[W-1]}}, a} - {{2{b[W-1]}}, b});
    endfunction

    function automatic logic signed [W-1:0] clip1(input logic signed [W-1:0] v);
        if (v > c_one)          clip1 = c_one;
        else if (v < c_neg_one) clip1 = c_neg_one;
        else                    clip1 = v;
    endfunction

    state_t r_state;
    state_t w_next;
    logic [2:0] r_step;
    logic       w_last;
    logic       w_accept;

    logic signed [W-1:0] r_x1, r_x2, r_y1, r_y2, r_mu, r_t;
    logic signed [W-1:0] r_h11, r_h12, r_h21, r_h22;
    logic signed [W-1:0] r_db11, r_db12, r_db21, r_db22;
    logic signed [W-1:0] r_nb11, r_nb12, r_nb21;
    logic signed [W-1:0] r_b11, r_b12, r_b21, r_b22;
    logic signed [W-1:0] r_y1_out, r_y2_out;
    logic                r_adapt;
    logic                r_out_valid;
`ifdef ICA_MIX_EN
    logic signed [W-1:0] r_s1, r_s2;
`endif

    logic signed [W-1:0]   w_ma, w_mb, w_p, w_f1, w_f2;
    logic signed [2*W-1:0] w_prod, w_prod_sh;

    assign in_ready  = (r_state == S_IDLE) && !r_out_valid && !clear_b;
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign y1_out    = r_y1_out;
    assign y2_out    = r_y2_out;
    assign x1_out    = r_x1;
    assign x2_out    = r_x2;
    assign B11_out   = r_b11;
    assign B12_out   = r_b12;
    assign B21_out   = r_b21;
    assign B22_out   = r_b22;

    assign w_f1 = clip1(r_y1);
    assign w_f2 = clip1(r_y2);

    // Shared multiplier: full 2W product, floor shift, then clamp to W bits so
    // an oversized product can never wrap before it enters a sum.
    assign w_prod    = $signed({{W{w_ma[W-1]}}, w_ma}) * $signed({{W{w_mb[W-1]}}, w_mb});
    assign w_prod_sh = w_prod >>> FRAC;
    assign w_p = ((&w_prod_sh[2*W-1:W-1]) || !(|w_prod_sh[2*W-1:W-1]))
               ? w_prod_sh[W-1:0]
               : (w_prod_sh[2*W-1] ? c_min : c_max);

    // Operand selection for the current step.
    always_comb begin
        w_ma = '0;
        w_mb = '0;
        case (r_state)
`ifdef ICA_MIX_EN
            S_MIX: begin
                case (r_step)
                    3'd0:    begin w_ma = c_a11; w_mb = r_s1; end
                    3'd1:    begin w_ma = c_a12; w_mb = r_s2; end
                    3'd2:    begin w_ma = c_a21; w_mb = r_s1; end
                    default: begin w_ma = c_a22; w_mb = r_s2; end
                endcase
            end
`endif
            S_Y: begin
                case (r_step)
                    3'd0:    begin w_ma = r_x1; w_mb = r_b11; end
                    3'd1:    begin w_ma = r_x2; w_mb = r_b12; end
                    3'd2:    begin w_ma = r_x1; w_mb = r_b21; end
                    default: begin w_ma = r_x2; w_mb = r_b22; end
                endcase
            end
            S_H: begin
                case (r_step)
                    3'd0:    begin w_ma = r_y1; w_mb = r_y1; end
                    3'd1:    begin w_ma = r_y2; w_mb = r_y2; end
                    3'd2:    begin w_ma = r_y2; w_mb = w_f1; end
                    3'd3:    begin w_ma = r_y1; w_mb = r_y2; end
                    default: begin w_ma = r_y1; w_mb = w_f2; end
                endcase
            end
            S_DB: begin
                case (r_step)
                    3'd0:    begin w_ma = r_b11; w_mb = r_h11; end
                    3'd1:    begin w_ma = r_h12; w_mb = r_b21; end
                    3'd2:    begin w_ma = r_b12; w_mb = r_h11; end
                    3'd3:    begin w_ma = r_h12; w_mb = r_b22; end
                    3'd4:    begin w_ma = r_b11; w_mb = r_h21; end
                    3'd5:    begin w_ma = r_h22; w_mb = r_b21; end
                    3'd6:    begin w_ma = r_b12; w_mb = r_h21; end
                    default: begin w_ma = r_h22; w_mb = r_b22; end
                endcase
            end
            S_UPD: begin
                w_ma = r_mu;
                case (r_step)
                    3'd0:    w_mb = r_db11;
                    3'd1:    w_mb = r_db12;
                    3'd2:    w_mb = r_db21;
                    default: w_mb = r_db22;
                endcase
            end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        w_last = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = c_first;
`ifdef ICA_MIX_EN
            S_MIX: begin
                w_last = (r_step == 3'd3);
                if (w_last) w_next = S_Y;
            end
`endif
            S_Y: begin
                w_last = (r_step == 3'd3);
                if (w_last) w_next = S_H;
            end
            S_H: begin
                w_last = (r_step == 3'd4);
                if (w_last) w_next = S_DB;
            end
            S_DB: begin
                w_last = (r_step == 3'd7);
                if (w_last) w_next = S_UPD;
            end
            S_UPD: begin
                w_last = (r_step == 3'd3);
                if (w_last) w_next = S_OUT;
            end
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_step  <= 3'd0;
        end else begin
            r_state <= w_next;
            r_step  <= (w_next != r_state || r_state == S_IDLE) ? 3'd0 : r_step + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x1 <= '0;  r_x2 <= '0;  r_y1 <= '0;  r_y2 <= '0;
            r_mu <= '0;  r_t  <= '0;  r_adapt <= 1'b0;
            r_h11 <= '0; r_h12 <= '0; r_h21 <= '0; r_h22 <= '0;
            r_db11 <= '0; r_db12 <= '0; r_db21 <= '0; r_db22 <= '0;
            r_nb11 <= '0; r_nb12 <= '0; r_nb21 <= '0;
            r_b11 <= c_one; r_b12 <= '0; r_b21 <= '0; r_b22 <= c_one;
            r_y1_out <= '0; r_y2_out <= '0;
            r_out_valid <= 1'b0;
`ifdef ICA_MIX_EN
            r_s1 <= '0; r_s2 <= '0;
`endif
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear_b) begin
                        r_b11 <= c_one; r_b12 <= '0; r_b21 <= '0; r_b22 <= c_one;
                    end
                    if (w_accept) begin
                        r_mu    <= mu;
                        r_adapt <= adapt_en;
`ifdef ICA_MIX_EN
                        r_s1 <= in1;
                        r_s2 <= in2;
`else
                        r_x1 <= in1;
                        r_x2 <= in2;
`endif
                    end
                end
`ifdef ICA_MIX_EN
                S_MIX: begin
                    case (r_step)
                        3'd0:    r_x1 <= w_p;
                        3'd1:    r_x1 <= add_sat(r_x1, w_p);
                        3'd2:    r_x2 <= w_p;
                        default: r_x2 <= sub_sat(r_x2, w_p);
                    endcase
                end
`endif
                S_Y: begin
                    case (r_step)
                        3'd0:    r_y1 <= w_p;
                        3'd1:    r_y1 <= add_sat(r_y1, w_p);
                        3'd2:    r_y2 <= w_p;
                        default: r_y2 <= add_sat(r_y2, w_p);
                    endcase
                end
                S_H: begin
                    // H12/H21 share three products; r_t keeps y2*f1 and r_h21
                    // parks y1*y2 so both are evaluated strictly left to right.
                    case (r_step)
                        3'd0: r_h11 <= sub_sat(c_one, w_p);
                        3'd1: r_h22 <= sub_sat(c_one, w_p);
                        3'd2: r_t   <= w_p;
                        3'd3: begin
                            r_h12 <= sub_sat(r_t, w_p);
                            r_h21 <= w_p;
                        end
                        default: begin
                            r_h12 <= sub_sat(r_h12, w_p);
                            r_h21 <= sub_sat(sub_sat(w_p, r_h21), r_t);
                        end
                    endcase
                end
                S_DB: begin
                    case (r_step)
                        3'd0:    r_db11 <= w_p;
                        3'd1:    r_db11 <= add_sat(r_db11, w_p);
                        3'd2:    r_db12 <= w_p;
                        3'd3:    r_db12 <= add_sat(r_db12, w_p);
                        3'd4:    r_db21 <= w_p;
                        3'd5:    r_db21 <= add_sat(r_db21, w_p);
                        3'd6:    r_db22 <= w_p;
                        default: r_db22 <= add_sat(r_db22, w_p);
                    endcase
                end
                S_UPD: begin
                    // New coefficients are staged so all four land on one edge.
                    case (r_step)
                        3'd0: r_nb11 <= add_sat(r_b11, w_p);
                        3'd1: r_nb12 <= add_sat(r_b12, w_p);
                        3'd2: r_nb21 <= add_sat(r_b21, w_p);
                        default: begin
                            if (r_adapt) begin
                                r_b11 <= r_nb11;
                                r_b12 <= r_nb12;
                                r_b21 <= r_nb21;
                                r_b22 <= add_sat(r_b22, w_p);
                            end
                        end
                    endcase
                end
                S_OUT: begin
                    r_y1_out    <= r_y1;
                    r_y2_out    <= r_y2;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ica_easi_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ica_easi_seq
//  Description : Directed bench for ica_easi_seq. The driver pushes the
//                hand-computed result of each accepted sample into a queue.
//                A monitor pops it when out_valid rises and compares it with
//                the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ica_easi_seq;

    localparam logic [31:0] ONE = 32'h0001_0000;
`ifdef ICA_MIX_EN
    localparam int LAT = 26;
`else
    localparam int LAT = 22;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        adapt_en = 1'b0;
    logic        clear_b = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in1 = '0, in2 = '0, mu = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] y1_out, y2_out, x1_out, x2_out, b11, b12, b21, b22;

    ica_easi_seq #(.W(32), .FRAC(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .mu(mu), .adapt_en(adapt_en), .clear_b(clear_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y1_out(y1_out), .y2_out(y2_out), .x1_out(x1_out), .x2_out(x2_out),
        .B11_out(b11), .B12_out(b12), .B21_out(b21), .B22_out(b22),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] y1, y2, x1, x2, b11, b12, b21, b22;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] ey1, ey2, ex1, ex2,
                                input logic [31:0] eb11, eb12, eb21, eb22);
        exp_t e;
        e.y1 = ey1; e.y2 = ey2; e.x1 = ex1; e.x2 = ex2;
        e.b11 = eb11; e.b12 = eb12; e.b21 = eb21; e.b22 = eb22;
        e.acc = 0;
        return e;
    endfunction

    // Monitor: pops on out_valid rising, checks y every cycle it stays high.
    initial begin : monitor
        exp_t cur;
        logic have = 1'b0;
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && out_valid) begin
                if (!prev) begin
                    if (sb.size() == 0) begin
                        have = 1'b0;
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got out_valid=1 expected 0");
                    end else begin
                        cur  = sb.pop_front();
                        have = 1'b1;
                        chk("latency", 32'(cyc - cur.acc), LAT);
                        chk("x1_out", x1_out, cur.x1);
                        chk("x2_out", x2_out, cur.x2);
                        chk("B11", b11, cur.b11);
                        chk("B12", b12, cur.b12);
                        chk("B21", b21, cur.b21);
                        chk("B22", b22, cur.b22);
                    end
                end
                if (have) begin
                    chk("y1_out", y1_out, cur.y1);
                    chk("y2_out", y2_out, cur.y2);
                end
            end
            prev = reset && out_valid;
        end
    end

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL out_timeout: got out_valid=0 expected 1");
            return;
        end
        while (out_valid && n < 400) begin @(negedge clk); n++; end
        if (out_valid) begin
            checks++; errors++;
            $display("FAIL clear_timeout: got out_valid=1 expected 0");
        end
    endtask

    task automatic send(input logic [31:0] a, b, m, input logic ad,
                        input exp_t e, input bit wait_done);
        int   n;
        exp_t ee;
        ee = e;
        @(negedge clk);
        in1 = a; in2 = b; mu = m; adapt_en = ad; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        ee.acc = cyc;
        sb.push_back(ee);
        in_valid = 1'b0;
        if (wait_done) wait_out();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        exp_t e5;
        int   n;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_B11", b11, ONE);
        chk("rst_B12", b12, 32'h0);
        chk("rst_B21", b21, 32'h0);
        chk("rst_B22", b22, ONE);
        chk("rst_y1", y1_out, 32'h0);
        chk("rst_x1", x1_out, 32'h0);

`ifdef ICA_MIX_EN
        send(ONE, 32'h0, 32'h0, 1'b1,
             mk(32'h0000C000, 32'h00008000, 32'h0000C000, 32'h00008000,
                ONE, 32'h0, 32'h0, ONE), 1'b1);
`else
        // Unit input, identity B, mu=0.
        send(ONE, 32'h0, 32'h0, 1'b1,
             mk(ONE, 32'h0, ONE, 32'h0, ONE, 32'h0, 32'h0, ONE), 1'b1);

        // Half input with mu=0.5: H11=0.75, H22=1 gives B11=1.375, B22=1.5.
        send(32'h00008000, 32'h0, 32'h00008000, 1'b1,
             mk(32'h00008000, 32'h0, 32'h00008000, 32'h0,
                32'h00016000, 32'h0, 32'h0, 32'h00018000), 1'b1);

        // clear_b in IDLE blocks in_ready for that cycle and restores identity.
        @(negedge clk);
        clear_b = 1'b1;
        #1;
        chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        clear_b = 1'b0;
        chk("clear_B11", b11, ONE);
        chk("clear_B22", b22, ONE);

        // Same sample with adaptation frozen.
        send(32'h00008000, 32'h0, 32'h00008000, 1'b0,
             mk(32'h00008000, 32'h0, 32'h00008000, 32'h0, ONE, 32'h0, 32'h0, ONE), 1'b1);

        // x=(0,1), mu=0.25: DB11=1 only, so B11=1.25. Output is held by backpressure.
        out_ready = 1'b0;
        send(32'h0, ONE, 32'h00004000, 1'b1,
             mk(32'h0, ONE, 32'h0, ONE, 32'h00014000, 32'h0, 32'h0, ONE), 1'b0);
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        in1 = ONE; in2 = ONE; mu = 32'h00004000; adapt_en = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("held_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        // x=(1,1) with B=diag(1.25,1): y=(1.25,1), H11=-0.5625, H12=-1.5,
        // H21=-1, H22=0, giving B=(1.07421875,-0.375,-0.3125,1).
        e5 = mk(32'h00014000, ONE, ONE, ONE,
                32'h00011300, 32'hFFFFA000, 32'hFFFFB000, ONE);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        e5.acc = cyc + 1;
        sb.push_back(e5);
        chk("pulse_out_valid", {31'd0, out_valid}, 32'd0);
        chk("pulse_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pulse_accept_busy", {31'd0, busy}, 32'd1);
        wait_out();

        // Both sums saturate: y1 clamps low, y2 clamps high. B is frozen.
        send(32'h80000000, 32'h7FFFFFFF, 32'h0, 1'b0,
             mk(32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                32'h00011300, 32'hFFFFA000, 32'hFFFFB000, ONE), 1'b1);

        // clear_b while busy is ignored; reset at edge 12 aborts the sample.
        @(negedge clk);
        in1 = ONE; in2 = 32'h0; mu = 32'h00008000; adapt_en = 1'b1; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear_b = 1'b1;
        @(posedge clk);
        #1;
        clear_b = 1'b0;
        chk("busy_clear_busy", {31'd0, busy}, 32'd1);
        chk("busy_clear_B11", b11, 32'h00011300);
        chk("busy_clear_B12", b12, 32'hFFFFA000);
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_B11", b11, ONE);
        chk("abort_B12", b12, 32'h0);
        chk("abort_B21", b21, 32'h0);
        chk("abort_B22", b22, ONE);
        chk("abort_y1", y1_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Recovery after the abort.
        send(ONE, 32'h0, 32'h0, 1'b1,
             mk(ONE, 32'h0, ONE, 32'h0, ONE, 32'h0, 32'h0, ONE), 1'b1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
